mul_arbiter: RTL and testbench

Sequencer and two-port arbiter for the shared repeated-addition multiplier datapath (A register, P accumulator, B down-counter, adder, zero comparator). It grants the datapath to one of two requesters in round-robin order and latches that requester's operands. It drives the datapath load, clear and decrement strobes and its shared input bus, then captures the product and returns it with a one-cycle done pulse. It replaces the free-running controller: all sequencing is synchronous, with no intra-cycle delays.

---
 rtl/mul_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_mul_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_arbiter.sv
// mul_arbiter
//   Round-robin arbiter and sequencer for the shared repeated-addition
//   multiplier datapath (A register, P accumulator, B down-counter, adder,
//   zero comparator). It grants one of two requesters, latches that
//   requester's operands and steps the datapath through load, clear and
//   accumulate. It then captures P as the product and returns it with a
//   one-cycle done pulse.
//
// Build option
//   MUL_ARB_SWAP_EN  when defined, the larger operand is loaded into A and
//                    the smaller one into B. This keeps the accumulate loop
//                    as short as possible. The product is the same either way.
//
// Ports
//   clk, rst          clock and synchronous active-high reset
//   req0/req1         requests, held until the matching done pulse
//   a0,b0 / a1,b1     operands, sampled in the grant cycle only
//   gnt0/gnt1         grant, high from the grant edge through the DONE cycle
//   done0/done1       one-cycle completion pulse, result valid alongside
//   result            last product, held until the next completion
//   busy              high whenever the sequencer is not idle
//   dp_bus            operand value driven onto the datapath input bus
//   LdA,LdB,LdP,clrP,decB  registered datapath strobes
//   eqz, p_in         datapath B==0 flag and P register value
module mul_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic [WIDTH-1:0] dp_bus,
  output logic             LdA,
  output logic             LdB,
  output logic             LdP,
  output logic             clrP,
  output logic             decB,
  input  logic             eqz,
  input  logic [WIDTH-1:0] p_in
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LDA  = 3'd1,
    S_LDB  = 3'd2,
    S_ACC  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic             sel_q, sel_d;       // port that owns the current operation
  logic             last_q, last_d;     // port granted most recently
  logic             gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic             done0_q, done0_d, done1_q, done1_d;
  logic             busy_q, busy_d;
  logic             lda_q, lda_d, ldb_q, ldb_d, ldp_q, ldp_d;
  logic             clrp_q, clrp_d, decb_q, decb_d;
  logic [WIDTH-1:0] bus_q, bus_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;       // shadow of the datapath B counter
  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d;

  logic             any_req;
  logic             win;
  logic [WIDTH-1:0] cand_a, cand_b;

  // On a tie the port that was not granted last wins; otherwise the lone
  // requester wins.
  assign any_req = req0 | req1;
  assign win     = (req0 && req1) ? ~last_q : req1;

  always_comb begin
    cand_a = win ? a1 : a0;
    cand_b = win ? b1 : b0;
`ifdef MUL_ARB_SWAP_EN
    if (cand_b > cand_a) begin
      cand_a = win ? b1 : b0;
      cand_b = win ? a1 : a0;
    end
`endif
  end

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sel_q    <= 1'b0;
      last_q   <= 1'b1;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      busy_q   <= 1'b0;
      lda_q    <= 1'b0;
      ldb_q    <= 1'b0;
      ldp_q    <= 1'b0;
      clrp_q   <= 1'b0;
      decb_q   <= 1'b0;
      bus_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      last_q   <= last_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      busy_q   <= busy_d;
      lda_q    <= lda_d;
      ldb_q    <= ldb_d;
      ldp_q    <= ldp_d;
      clrp_q   <= clrp_d;
      decb_q   <= decb_d;
      bus_q    <= bus_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
    end
  end

  // Latched operands carry no reset; they are only read after a grant.
  always_ff @(posedge clk) begin
    opa_q <= opa_d;
    opb_q <= opb_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (any_req) state_d = S_LDA;
      S_LDA:  state_d = S_LDB;
      S_LDB:  state_d = S_ACC;
      S_ACC:  if (eqz) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: next values of every registered output
  always_comb begin
    sel_d    = sel_q;
    last_d   = last_q;
    gnt0_d   = gnt0_q;
    gnt1_d   = gnt1_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    cnt_d    = cnt_q;
    result_d = result_q;

    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          sel_d  = win;
          gnt0_d = ~win;
          gnt1_d = win;
          opa_d  = cand_a;
          opb_d  = cand_b;
        end
      end
      // B is loaded from the bus at the end of LDB.
      S_LDB: cnt_d = opb_q;
      S_ACC: begin
        if (eqz) begin
          result_d = p_in;
        end else if (decb_q) begin
          cnt_d = cnt_q - WIDTH'(1);
        end
      end
      S_DONE: begin
        gnt0_d = 1'b0;
        gnt1_d = 1'b0;
        last_d = sel_q;
      end
      default: ;
    endcase

    // Strobes are decoded one edge early so they leave the block straight
    // from flops. The shadow counter predicts what B will hold when the
    // strobe is live, so no accumulate pulse is issued once B reaches zero.
    busy_d  = (state_d != S_IDLE);
    lda_d   = (state_d == S_LDA);
    ldb_d   = (state_d == S_LDB);
    clrp_d  = (state_d == S_LDB);
    ldp_d   = (state_d == S_ACC) && (cnt_d != '0);
    decb_d  = (state_d == S_ACC) && (cnt_d != '0);
    done0_d = (state_d == S_DONE) && ~sel_q;
    done1_d = (state_d == S_DONE) && sel_q;

    if (state_d == S_LDA)      bus_d = opa_d;
    else if (state_d == S_LDB) bus_d = opb_q;
    else                       bus_d = '0;
  end

  assign gnt0   = gnt0_q;
  assign gnt1   = gnt1_q;
  assign done0  = done0_q;
  assign done1  = done1_q;
  assign busy   = busy_q;
  assign result = result_q;
  assign dp_bus = bus_q;
  assign LdA    = lda_q;
  assign LdB    = ldb_q;
  assign LdP    = ldp_q;
  assign clrP   = clrp_q;
  assign decB   = decb_q;

endmodule

// File: tb/tb_mul_arbiter.sv
module tb_mul_arbiter;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0 = 1'b0, req1 = 1'b0;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic         gnt0, gnt1, done0, done1, busy;
  logic [W-1:0] result, dp_bus;
  logic         LdA, LdB, LdP, clrP, decB;
  logic         eqz;
  logic [W-1:0] p_in;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit last_m = 1'b1;

  // Datapath the arbiter drives
  logic [W-1:0] dpA = '0, dpB = '0, dpP = '0;

  mul_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .result(result), .busy(busy), .dp_bus(dp_bus),
    .LdA(LdA), .LdB(LdB), .LdP(LdP), .clrP(clrP), .decB(decB),
    .eqz(eqz), .p_in(p_in)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (LdA) dpA <= dp_bus;
    if (LdB) dpB <= dp_bus;
    else if (decB) dpB <= dpB - 16'd1;
    if (clrP) dpP <= '0;
    else if (LdP) dpP <= dpP + dpA;
  end
  assign eqz  = (dpB == '0);
  assign p_in = dpP;

  // Reference: accumulate count and wrapped product
  function automatic int n_of(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MUL_ARB_SWAP_EN
    return (a < b) ? int'(a) : int'(b);
`else
    return int'(b);
`endif
  endfunction

  function automatic logic [W-1:0] prod(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [31:0] full;
    full = {16'd0, a} * {16'd0, b};
    return full[W-1:0];
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    last_m = 1'b1;
  endtask

  // Raise the enabled requests together and observe until each completes.
  task automatic run_pair(
    input  bit en0, input logic [W-1:0] xa0, input logic [W-1:0] xb0,
    input  bit en1, input logic [W-1:0] xa1, input logic [W-1:0] xb1,
    output int rel0, output int rel1,
    output logic [W-1:0] res0, output logic [W-1:0] res1,
    output int ldp_cnt, output int busy_cnt, output int first_gnt1,
    output int lda_rel, output int ldb_rel, output bit tmo, output int spurious);
    int start, r;
    bit p0, p1;
    rel0 = -1; rel1 = -1; res0 = '0; res1 = '0;
    ldp_cnt = 0; busy_cnt = 0; first_gnt1 = -1;
    lda_rel = -1; ldb_rel = -1; spurious = 0;
    @(posedge clk); #1;
    a0 = xa0; b0 = xb0; a1 = xa1; b1 = xb1;
    req0 = en0; req1 = en1;
    p0 = en0; p1 = en1;
    start = cyc;
    for (int k = 0; k < 400 && (p0 || p1); k++) begin
      @(negedge clk);
      r = cyc - start;
      if (LdP) ldp_cnt++;
      if (busy) busy_cnt++;
      if (LdA && lda_rel < 0) lda_rel = r;
      if (LdB && clrP && ldb_rel < 0) ldb_rel = r;
      if (gnt1 && first_gnt1 < 0) first_gnt1 = r;
      if (gnt0 && !en0) spurious++;
      if (gnt1 && !en1) spurious++;
      if (done0) begin
        if (p0) begin rel0 = r; res0 = result; p0 = 1'b0; req0 = 1'b0; end
        else spurious++;
      end
      if (done1) begin
        if (p1) begin rel1 = r; res1 = result; p1 = 1'b0; req1 = 1'b0; end
        else spurious++;
      end
    end
    tmo = p0 || p1;
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({gnt0, gnt1, done0, done1, busy, LdA, LdB, LdP, clrP, decB} !== 10'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b want 0", {gnt0, gnt1, done0, done1, busy, LdA, LdB, LdP, clrP, decB});
    end
    vectors++;
    if (dp_bus !== 16'd0) begin miscompares++; $display("FAIL reset_bus: got %0d want 0", dp_bus); end
    vectors++;
    if (result !== 16'd0) begin miscompares++; $display("FAIL reset_result: got %0d want 0", result); end
    @(posedge clk); #1 rst = 1'b0;
    last_m = 1'b1;
  endtask

  task automatic test_basic();
    int r0, r1, ldp, bc, g1, la, lb, sp, n;
    logic [W-1:0] s0, s1;
    bit tmo;
    n = n_of(16'd3, 16'd4);
    run_pair(1'b1, 16'd3, 16'd4, 1'b0, 16'd0, 16'd0, r0, r1, s0, s1, ldp, bc, g1, la, lb, tmo, sp);
    last_m = 1'b0;
    vectors++;
    if (tmo !== 1'b0) begin miscompares++; $display("FAIL basic_timeout: got %0d want 0", tmo); end
    vectors++;
    if (r0 !== 4 + n) begin miscompares++; $display("FAIL basic_done_cycle: got %0d want %0d", r0, 4 + n); end
    vectors++;
    if (s0 !== 16'd12) begin miscompares++; $display("FAIL basic_result: got %0d want 12", s0); end
    vectors++;
    if (ldp !== n) begin miscompares++; $display("FAIL basic_ldp_count: got %0d want %0d", ldp, n); end
    vectors++;
    if (la !== 1) begin miscompares++; $display("FAIL basic_lda_cycle: got %0d want 1", la); end
    vectors++;
    if (lb !== 2) begin miscompares++; $display("FAIL basic_ldb_cycle: got %0d want 2", lb); end
    vectors++;
    if (bc !== 4 + n) begin miscompares++; $display("FAIL basic_busy_cycles: got %0d want %0d", bc, 4 + n); end
    vectors++;
    if (sp !== 0) begin miscompares++; $display("FAIL basic_spurious: got %0d want 0", sp); end
    repeat (3) @(negedge clk);
    vectors++;
    if (result !== 16'd12) begin miscompares++; $display("FAIL basic_result_hold: got %0d want 12", result); end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL basic_idle_busy: got %0d want 0", busy); end
  endtask

  task automatic test_wrap();
    int r0, r1, ldp, bc, g1, la, lb, sp;
    logic [W-1:0] s0, s1;
    bit tmo;
    run_pair(1'b0, 16'd0, 16'd0, 1'b1, 16'd300, 16'd300, r0, r1, s0, s1, ldp, bc, g1, la, lb, tmo, sp);
    last_m = 1'b1;
    vectors++;
    if (tmo !== 1'b0) begin miscompares++; $display("FAIL wrap_timeout: got %0d want 0", tmo); end
    vectors++;
    if (s1 !== 16'd24464) begin miscompares++; $display("FAIL wrap_result: got %0d want 24464", s1); end
    vectors++;
    if (r1 !== 304) begin miscompares++; $display("FAIL wrap_done_cycle: got %0d want 304", r1); end
    vectors++;
    if (sp !== 0) begin miscompares++; $display("FAIL wrap_port0_activity: got %0d want 0", sp); end
  endtask

  task automatic test_zero_b();
    int r0, r1, ldp, bc, g1, la, lb, sp;
    logic [W-1:0] s0, s1;
    bit tmo;
    run_pair(1'b1, 16'd7, 16'd0, 1'b0, 16'd0, 16'd0, r0, r1, s0, s1, ldp, bc, g1, la, lb, tmo, sp);
    last_m = 1'b0;
    vectors++;
    if (r0 !== 4) begin miscompares++; $display("FAIL zero_done_cycle: got %0d want 4", r0); end
    vectors++;
    if (s0 !== 16'd0) begin miscompares++; $display("FAIL zero_result: got %0d want 0", s0); end
    vectors++;
    if (ldp !== 0) begin miscompares++; $display("FAIL zero_ldp_count: got %0d want 0", ldp); end
  endtask

  task automatic test_tie();
    int r0, r1, ldp, bc, g1, la, lb, sp, n0, n1;
    logic [W-1:0] s0, s1;
    bit tmo;
    do_reset();
    n0 = n_of(16'd2, 16'd2);
    n1 = n_of(16'd5, 16'd1);
    run_pair(1'b1, 16'd2, 16'd2, 1'b1, 16'd5, 16'd1, r0, r1, s0, s1, ldp, bc, g1, la, lb, tmo, sp);
    last_m = 1'b1;
    vectors++;
    if (r0 !== 4 + n0) begin miscompares++; $display("FAIL tie_done0_cycle: got %0d want %0d", r0, 4 + n0); end
    vectors++;
    if (s0 !== 16'd4) begin miscompares++; $display("FAIL tie_result0: got %0d want 4", s0); end
    vectors++;
    if (g1 !== r0 + 2) begin miscompares++; $display("FAIL tie_gnt1_cycle: got %0d want %0d", g1, r0 + 2); end
    vectors++;
    if (r1 !== r0 + 5 + n1) begin miscompares++; $display("FAIL tie_done1_cycle: got %0d want %0d", r1, r0 + 5 + n1); end
    vectors++;
    if (s1 !== 16'd5) begin miscompares++; $display("FAIL tie_result1: got %0d want 5", s1); end
    // port 1 finished last, so port 0 takes the next tie
    run_pair(1'b1, 16'd3, 16'd3, 1'b1, 16'd4, 16'd2, r0, r1, s0, s1, ldp, bc, g1, la, lb, tmo, sp);
    last_m = 1'b1;
    vectors++;
    if (r0 !== 4 + n_of(16'd3, 16'd3)) begin miscompares++; $display("FAIL tie2_done0_cycle: got %0d want %0d", r0, 4 + n_of(16'd3, 16'd3)); end
    vectors++;
    if (r1 !== r0 + 5 + n_of(16'd4, 16'd2)) begin miscompares++; $display("FAIL tie2_done1_cycle: got %0d want %0d", r1, r0 + 5 + n_of(16'd4, 16'd2)); end
    vectors++;
    if ({s0, s1} !== {16'd9, 16'd8}) begin miscompares++; $display("FAIL tie2_results: got %0d/%0d want 9/8", s0, s1); end
  endtask

  task automatic test_reset_mid();
    int r0, r1, ldp, bc, g1, la, lb, sp, dn;
    logic [W-1:0] s0, s1;
    bit tmo;
    do_reset();
    @(posedge clk); #1;
    a0 = 16'd9; b0 = 16'd20; req0 = 1'b1;
    repeat (6) @(posedge clk);
    #1 rst = 1'b1; req0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if ({gnt0, gnt1, done0, done1, busy, LdA, LdB, LdP, clrP, decB} !== 10'b0) begin
      miscompares++;
      $display("FAIL midrst_ctrl: got %b want 0", {gnt0, gnt1, done0, done1, busy, LdA, LdB, LdP, clrP, decB});
    end
    vectors++;
    if ({dp_bus, result} !== 32'd0) begin miscompares++; $display("FAIL midrst_data: got %h want 0", {dp_bus, result}); end
    @(posedge clk); #1 rst = 1'b0;
    last_m = 1'b1;
    dn = 0;
    repeat (10) begin
      @(negedge clk);
      if (done0 || done1) dn++;
    end
    vectors++;
    if (dn !== 0) begin miscompares++; $display("FAIL midrst_no_done: got %0d want 0", dn); end
    run_pair(1'b1, 16'd3, 16'd5, 1'b0, 16'd0, 16'd0, r0, r1, s0, s1, ldp, bc, g1, la, lb, tmo, sp);
    last_m = 1'b0;
    vectors++;
    if (s0 !== 16'd15) begin miscompares++; $display("FAIL midrst_fresh_result: got %0d want 15", s0); end
    vectors++;
    if (r0 !== 4 + n_of(16'd3, 16'd5)) begin miscompares++; $display("FAIL midrst_fresh_cycle: got %0d want %0d", r0, 4 + n_of(16'd3, 16'd5)); end
  endtask

  task automatic test_random();
    int r0, r1, ldp, bc, g1, la, lb, sp, mode, e0, e1, na, nb;
    logic [W-1:0] s0, s1, xa0, xb0, xa1, xb1;
    bit tmo, en0, en1, w;
    for (int it = 0; it < 24; it++) begin
      mode = $urandom_range(0, 2);
      en0 = (mode != 1);
      en1 = (mode != 0);
      xa0 = 16'($urandom); xb0 = 16'($urandom_range(0, 40));
      xa1 = 16'($urandom); xb1 = 16'($urandom_range(0, 40));
      if ($urandom_range(0, 3) == 0) xa0 = 16'($urandom_range(0, 3));
      w = (en0 && en1) ? ~last_m : en1;
      na = w ? n_of(xa1, xb1) : n_of(xa0, xb0);
      nb = w ? n_of(xa0, xb0) : n_of(xa1, xb1);
      if (en0 && en1) begin
        e0 = w ? 9 + na + nb : 4 + na;
        e1 = w ? 4 + na : 9 + na + nb;
        last_m = ~w;
      end else begin
        e0 = en0 ? 4 + na : -1;
        e1 = en1 ? 4 + na : -1;
        last_m = w;
      end
      run_pair(en0, xa0, xb0, en1, xa1, xb1, r0, r1, s0, s1, ldp, bc, g1, la, lb, tmo, sp);
      vectors++;
      if (r0 !== e0 || r1 !== e1) begin
        miscompares++;
        $display("FAIL rand%0d_done_cycles: got %0d/%0d want %0d/%0d", it, r0, r1, e0, e1);
      end
      vectors++;
      if ((en0 && s0 !== prod(xa0, xb0)) || (en1 && s1 !== prod(xa1, xb1))) begin
        miscompares++;
        $display("FAIL rand%0d_results: got %0d/%0d want %0d/%0d", it, s0, s1, prod(xa0, xb0), prod(xa1, xb1));
      end
      vectors++;
      if (sp !== 0 || tmo !== 1'b0) begin
        miscompares++;
        $display("FAIL rand%0d_protocol: got spurious=%0d timeout=%0d want 0/0", it, sp, tmo);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_zero_b();
    test_tie();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
